// File: rtl/aes_rr_scheduler_pkg.sv
// Shared types and constants for the AES round-robin scheduler slice.
package aes_sched_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int MAX_NUM_REQ = 8;

  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [$clog2(MAX_NUM_REQ)-1:0] req_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_e;

endpackage

// File: rtl/aes_rr_scheduler_if.sv
// Requester and AES-core facing signals of the scheduler.
// master = requesters plus core (environment), slave = scheduler.
interface aes_rr_scheduler_if #(parameter int NUM_REQ = 4);
  import aes_sched_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_plain_text;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_cipher_key;

  logic       core_valid_in;
  aes_block_t core_plan_text_128;
  aes_block_t core_cipher_key_128;
  logic       core_valid_out;
  aes_block_t core_cipher_text_128;

  logic [NUM_REQ-1:0] rsp_valid;
  aes_block_t         rsp_cipher_text;

  modport master (
    output req_valid, req_plain_text, req_cipher_key,
    output core_valid_out, core_cipher_text_128,
    input  req_ready, core_valid_in, core_plan_text_128, core_cipher_key_128,
    input  rsp_valid, rsp_cipher_text
  );

  modport slave (
    input  req_valid, req_plain_text, req_cipher_key,
    input  core_valid_out, core_cipher_text_128,
    output req_ready, core_valid_in, core_plan_text_128, core_cipher_key_128,
    output rsp_valid, rsp_cipher_text
  );

endinterface

// File: rtl/aes_tag_fifo.sv
// In-order FIFO of requester tags for blocks in flight in the AES core.
// When empty, head shows push_data so a same-cycle push and pop pass straight through.
module aes_tag_fifo
  import aes_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  req_idx_t               push_data,
  input  logic                   pop,
  output req_idx_t               head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  req_idx_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && (!empty || push);
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? push_data : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/aes_rr_scheduler.sv
// Round-robin sharing of one AES-128 core between NUM_REQ requesters,
// with in-order tag tracking to route each result back to its issuer.
module aes_rr_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_enable,
  aes_rr_scheduler_if.slave                bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                             idle,
  output logic                             err_unexpected
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  sched_state_e state;
  sched_state_e state_next;
  req_idx_t     ptr;
  req_idx_t     cand;
  req_idx_t     grant_idx;
  req_idx_t     tag_head;
  logic         grant_any;
  logic         can_issue;
  logic         fire;
  logic         pop;
  logic         fifo_empty;
  logic         fifo_full;
  aes_block_t   sel_plain;
  aes_block_t   sel_key;

  // A result leaving the core in this cycle frees a slot for a new grant.
  assign can_issue = (state != DRAIN) && cfg_enable && (!fifo_full || bus.core_valid_out);
  assign fire      = grant_any && can_issue;
  assign pop       = bus.core_valid_out && (!fifo_empty || fire);
  assign idle      = (state == IDLE);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = req_idx_t'((int'(ptr) + k) % NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && bus.req_valid[i] && (cand == req_idx_t'(i))) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    sel_plain     = '0;
    sel_key       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == req_idx_t'(i)) begin
        bus.req_ready[i] = fire;
        sel_plain        = bus.req_plain_text[AES_BLOCK_W*i +: AES_BLOCK_W];
        sel_key          = bus.req_cipher_key[AES_BLOCK_W*i +: AES_BLOCK_W];
      end
    end
  end

  aes_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fire),
    .push_data (grant_idx),
    .pop       (bus.core_valid_out),
    .head      (tag_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // DRAIN leaves as soon as the final pop lands, so idle rises with the last count decrement.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (fire) state_next = RUN;
      RUN: begin
        if (!cfg_enable && (outstanding != '0))      state_next = DRAIN;
        else if ((outstanding == '0) && !fire)       state_next = IDLE;
      end
      DRAIN: if ((outstanding == '0) || ((outstanding == CNT_W'(1)) && pop)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr                     <= '0;
      bus.core_valid_in       <= 1'b0;
      bus.core_plan_text_128  <= '0;
      bus.core_cipher_key_128 <= '0;
      bus.rsp_valid           <= '0;
      bus.rsp_cipher_text     <= '0;
      err_unexpected          <= 1'b0;
    end else begin
      bus.core_valid_in <= fire;
      if (fire) begin
        bus.core_plan_text_128  <= sel_plain;
        bus.core_cipher_key_128 <= sel_key;
        ptr                     <= req_idx_t'((int'(grant_idx) + 1) % NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.rsp_valid[i] <= pop && (tag_head == req_idx_t'(i));
      end
      if (pop) bus.rsp_cipher_text <= bus.core_cipher_text_128;
      if (bus.core_valid_out && !pop) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_rr_scheduler.sv
// Directed bench for aes_rr_scheduler: behavioural AES core stand-in plus
// issue/response scoreboards fed by the stimulus and drained by monitors.
module tb_aes_rr_scheduler;
  import aes_sched_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int MAX_OUT  = 16;
  localparam int CORE_LAT = 4;

  localparam aes_block_t FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct { aes_block_t p; aes_block_t k; } issue_t;
  typedef struct { logic [NUM_REQ-1:0] oh; aes_block_t c; } rsp_t;
  typedef struct { aes_block_t c; int t; } core_t;

  logic                       clk;
  logic                       reset;
  logic                       cfg_enable;
  logic [$clog2(MAX_OUT):0]   outstanding;
  logic                       idle;
  logic                       err_unexpected;

  aes_rr_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  aes_rr_scheduler #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_enable     (cfg_enable),
    .bus            (bus),
    .outstanding    (outstanding),
    .idle           (idle),
    .err_unexpected (err_unexpected)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rsp_seen = 0;
  int step_req = 0;
  int spur_req = 0;
  logic core_stall = 1'b0;

  issue_t     exp_issue[$];
  rsp_t       exp_rsp[$];
  core_t      core_q[$];
  aes_block_t cur_plain [NUM_REQ];
  aes_block_t cur_key   [NUM_REQ];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic aes_block_t fake_aes(input aes_block_t p, input aes_block_t k);
    if (p == FIPS_P && k == FIPS_K) return FIPS_C;
    return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a_5a5a_0f0f_0f0f_3c3c_3c3c_9696_9696;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_plain_text[128*i +: 128] = cur_plain[i];
      bus.req_cipher_key[128*i +: 128] = cur_key[i];
    end
    bus.req_valid = valid;
    #1;
  endtask

  task automatic expectGrant(input int idx);
    issue_t is;
    rsp_t   rs;
    is.p = cur_plain[idx];
    is.k = cur_key[idx];
    rs.oh = '0;
    rs.oh[idx] = 1'b1;
    rs.c = fake_aes(is.p, is.k);
    exp_issue.push_back(is);
    exp_rsp.push_back(rs);
  endtask

  // One handshake: check the grant before the edge, then give the winner fresh data.
  task automatic grantStep(input logic [NUM_REQ-1:0] valid, input int idx, input string name);
    @(negedge clk);
    applyStimulus(valid);
    checkOutput(name, 128'(bus.req_ready), 128'(1) << idx);
    expectGrant(idx);
    @(posedge clk);
    #1;
    cur_plain[idx] = cur_plain[idx] + 128'd1;
    cur_key[idx]   = cur_key[idx] ^ 128'h0101;
    applyStimulus(valid);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_issue.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 128'(exp_rsp.size() + exp_issue.size()), 128'd0);
    exp_rsp.delete();
    exp_issue.delete();
  endtask

  initial begin : core_model
    core_t ce;
    bus.core_valid_out       = 1'b0;
    bus.core_cipher_text_128 = '0;
    forever begin
      int step_done;
      int spur_done;
      @(negedge clk);
      if (reset !== 1'b1) begin
        core_q.delete();
        bus.core_valid_out       = 1'b0;
        bus.core_cipher_text_128 = '0;
        step_done = step_req;
        spur_done = spur_req;
      end else begin
        if (bus.core_valid_in === 1'b1) begin
          ce.c = fake_aes(bus.core_plan_text_128, bus.core_cipher_key_128);
          ce.t = cyc;
          core_q.push_back(ce);
        end
        bus.core_valid_out = 1'b0;
        if (spur_done != spur_req) begin
          spur_done++;
          bus.core_valid_out       = 1'b1;
          bus.core_cipher_text_128 = 128'hdead_beef_0000_0000_0000_0000_cafe_f00d;
        end else if (core_q.size() != 0 && cyc >= core_q[0].t + CORE_LAT &&
                     (!core_stall || step_done != step_req)) begin
          if (core_stall) step_done++;
          ce = core_q.pop_front();
          bus.core_valid_out       = 1'b1;
          bus.core_cipher_text_128 = ce.c;
        end
      end
    end
  end

  initial begin : issue_monitor
    issue_t e;
    forever begin
      @(negedge clk);
      if (bus.core_valid_in === 1'b1) begin
        if (exp_issue.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL issue_unexpected: got core_valid_in=1 expected no issue");
        end else begin
          e = exp_issue.pop_front();
          checkOutput("issue_plain", bus.core_plan_text_128, e.p);
          checkOutput("issue_key", bus.core_cipher_key_128, e.k);
        end
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid !== '0 && reset === 1'b1) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rsp_unexpected: got rsp_valid=%b expected none", bus.rsp_valid);
        end else begin
          e = exp_rsp.pop_front();
          checkOutput("rsp_route", 128'(bus.rsp_valid), 128'(e.oh));
          checkOutput("rsp_data", bus.rsp_cipher_text, e.c);
        end
      end
    end
  end

  initial begin : stimulus
    int seen0;
    reset          = 1'b1;
    cfg_enable     = 1'b0;
    bus.req_valid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_plain[i] = 128'ha0a0_0000_0000_0000_0000_0000_0000_0000 + 128'(i << 8);
      cur_key[i]   = 128'h0000_0000_1111_2222_3333_4444_5555_0000 + 128'(i);
    end
    applyStimulus('0);
    #1 reset = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_core_valid_in", 128'(bus.core_valid_in), 128'd0);
    checkOutput("rst_core_plain", bus.core_plan_text_128, 128'd0);
    checkOutput("rst_core_key", bus.core_cipher_key_128, 128'd0);
    checkOutput("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    checkOutput("rst_rsp_cipher", bus.rsp_cipher_text, 128'd0);
    checkOutput("rst_outstanding", 128'(outstanding), 128'd0);
    checkOutput("rst_idle", 128'(idle), 128'd1);
    checkOutput("rst_err", 128'(err_unexpected), 128'd0);
    @(negedge clk);
    reset      = 1'b1;
    cfg_enable = 1'b1;

    // Single request with the FIPS-197 vector on requester 2.
    cur_plain[2] = FIPS_P;
    cur_key[2]   = FIPS_K;
    grantStep(4'b0100, 2, "single_ready");
    applyStimulus('0);
    @(negedge clk);
    #1;
    checkOutput("single_issue_latency", 128'(bus.core_valid_in), 128'd1);
    checkOutput("single_outstanding", 128'(outstanding), 128'd1);
    checkOutput("single_not_idle", 128'(idle), 128'd0);
    waitDrain("single_rsp_drain");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("single_done_outstanding", 128'(outstanding), 128'd0);
    checkOutput("single_done_idle", 128'(idle), 128'd1);

    // Requester 3 moves the pointer back to 0, then all four compete.
    grantStep(4'b1000, 3, "rr_prelude_ready");
    applyStimulus('0);
    for (int k = 0; k < 8; k++) grantStep(4'b1111, k % 4, $sformatf("rr_grant%0d", k));
    applyStimulus('0);
    waitDrain("rr_rsp_drain");

    // Fill all slots with the core stalled.
    core_stall = 1'b1;
    for (int k = 0; k < MAX_OUT; k++) grantStep(4'b0010, 1, $sformatf("full_grant%0d", k));
    @(negedge clk);
    #1;
    checkOutput("full_ready_blocked", 128'(bus.req_ready), 128'd0);
    checkOutput("full_outstanding", 128'(outstanding), 128'd16);
    @(negedge clk);
    #1;
    checkOutput("full_ready_still_blocked", 128'(bus.req_ready), 128'd0);
    step_req++;
    grantStep(4'b0010, 1, "full_pop_grant");
    @(negedge clk);
    #1;
    checkOutput("full_after_pop_outstanding", 128'(outstanding), 128'd16);
    checkOutput("full_after_pop_blocked", 128'(bus.req_ready), 128'd0);
    applyStimulus('0);
    core_stall = 1'b0;
    waitDrain("full_rsp_drain");

    // Drain: five in flight, then cfg_enable drops and later rises inside DRAIN.
    core_stall = 1'b1;
    for (int k = 0; k < 5; k++) grantStep(4'b0001, 0, $sformatf("drain_grant%0d", k));
    @(negedge clk);
    cfg_enable = 1'b0;
    #1;
    checkOutput("drain_ready_cfg_off", 128'(bus.req_ready), 128'd0);
    @(negedge clk);
    cfg_enable = 1'b1;
    #1;
    checkOutput("drain_ready_ignored", 128'(bus.req_ready), 128'd0);
    checkOutput("drain_not_idle", 128'(idle), 128'd0);
    checkOutput("drain_outstanding", 128'(outstanding), 128'd5);
    @(negedge clk);
    #1;
    checkOutput("drain_ready_ignored2", 128'(bus.req_ready), 128'd0);
    applyStimulus('0);
    seen0      = rsp_seen;
    core_stall = 1'b0;
    waitDrain("drain_rsp_drain");
    #1;
    checkOutput("drain_pulse_count", 128'(rsp_seen - seen0), 128'd5);
    checkOutput("drain_idle", 128'(idle), 128'd1);
    checkOutput("drain_outstanding_zero", 128'(outstanding), 128'd0);

    // Core output with nothing in flight.
    @(negedge clk);
    #1;
    spur_req++;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("spur_err", 128'(err_unexpected), 128'd1);
    checkOutput("spur_no_rsp", 128'(bus.rsp_valid), 128'd0);
    checkOutput("spur_outstanding", 128'(outstanding), 128'd0);
    @(negedge clk);
    #1;
    checkOutput("spur_err_sticky", 128'(err_unexpected), 128'd1);

    // Reset with three blocks in flight.
    core_stall = 1'b1;
    for (int k = 0; k < 3; k++) grantStep(4'b1000, 3, $sformatf("rst_grant%0d", k));
    applyStimulus('0);
    @(negedge clk);
    #1;
    checkOutput("rstmid_outstanding_pre", 128'(outstanding), 128'd3);
    reset = 1'b0;
    #1;
    checkOutput("rstmid_core_valid_in", 128'(bus.core_valid_in), 128'd0);
    checkOutput("rstmid_core_plain", bus.core_plan_text_128, 128'd0);
    checkOutput("rstmid_core_key", bus.core_cipher_key_128, 128'd0);
    checkOutput("rstmid_rsp_cipher", bus.rsp_cipher_text, 128'd0);
    checkOutput("rstmid_outstanding", 128'(outstanding), 128'd0);
    checkOutput("rstmid_err", 128'(err_unexpected), 128'd0);
    checkOutput("rstmid_idle", 128'(idle), 128'd1);
    exp_rsp.delete();
    exp_issue.delete();
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    core_stall = 1'b0;
    seen0      = rsp_seen;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("rstmid_no_rsp", 128'(rsp_seen - seen0), 128'd0);
    checkOutput("rstmid_outstanding_post", 128'(outstanding), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
